// File: rtl/svo_uart_term_rx.sv
// svo_uart_term_rx: UART receiver feeding the HDMI terminal text path.
// It deserialises characters from the USB-UART pin into a byte FIFO.
// The FIFO drives a valid/ready byte stream, so renderer stalls lose nothing.
// Optional feature macro: SVO_UART_RX_PARITY_EN.
//   Undefined: frames are 8N1.
//   Defined:   frames are 8E1, and a bad parity bit drops the byte.
module svo_uart_term_rx #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic       out_axis_tvalid,
  input  logic       out_axis_tready,
  output logic [7:0] out_axis_tdata,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [NW-1:0] DEPTH_C = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SVO_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  logic          rx_meta_q;
  logic          rx_s_q;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          frame_err_q;
  logic          overrun_q;
`ifdef SVO_UART_RX_PARITY_EN
  logic          par_err_q;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;

  logic stop_sample;
  logic push;
  logic pop;
  logic push_ok;

  // Two-flop synchroniser for the asynchronous serial pin, idling high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // A good byte is pushed in the same cycle its stop bit is sampled high
  assign stop_sample = (state_q == S_STOP) && (cnt_q == '0);
`ifdef SVO_UART_RX_PARITY_EN
  assign push = stop_sample && rx_s_q && !par_err_q;
`else
  assign push = stop_sample && rx_s_q;
`endif

  // Frame FSM: mid-bit sampling driven by a down-counter, with a registered error pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef SVO_UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            cnt_q   <= HALF_M1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (!rx_s_q) begin
            cnt_q     <= DIV_M1;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            shift_q <= {rx_s_q, shift_q[7:1]};
            cnt_q   <= DIV_M1;
            if (bit_idx_q == 3'd7) begin
`ifdef SVO_UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
`ifdef SVO_UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            par_err_q <= rx_s_q ^ (^shift_q);
            cnt_q     <= DIV_M1;
            state_q   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (rx_s_q) begin
`ifdef SVO_UART_RX_PARITY_EN
            frame_err_q <= par_err_q;
`endif
            state_q <= S_IDLE;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign pop     = (count_q != '0) && out_axis_tready;
  assign push_ok = push && ((count_q != DEPTH_C) || pop);

  // Next-state pointer and occupancy arithmetic for the FIFO
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + NW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - NW'(1);
    end
  end

  // FIFO control registers, plus the overrun pulse raised when a good byte is dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= push && !push_ok;
    end
  end

  // Byte storage; left unreset so it can map onto distributed RAM
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign out_axis_tvalid = (count_q != '0);
  assign out_axis_tdata  = mem_q[rd_ptr_q];
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_svo_uart_term_rx.sv
// Self-checking bench for svo_uart_term_rx with DIV = 10.
// A scoreboard queue holds the bytes that must come out, in order.
module tb_svo_uart_term_rx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = 10;
  localparam int DEPTH    = 16;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       stopBit;
    logic       parityOk;
    int         expBeats;
    int         expFerr;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       tready = 1'b1;
  logic       tvalid;
  logic [7:0] tdata;
  logic       ferr;
  logic       ovr;

  int checkCount = 0;
  int passCount  = 0;
  int beatCount  = 0;
  int ferrCount  = 0;
  int ovrCount   = 0;
  logic [7:0] expQ[$];
  vec_t vecs[$];

  svo_uart_term_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx(rx),
    .out_axis_tvalid(tvalid),
    .out_axis_tready(tready),
    .out_axis_tdata(tdata),
    .frame_err(ferr),
    .overrun(ovr)
  );

  // 100 MHz-style free-running clock; only the cycle count matters
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    rx = b;
    repeat (DIV) tick();
  endtask

  // Drive one frame LSB-first; parityOk selects a correct or inverted even-parity bit
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parityOk);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
`ifdef SVO_UART_RX_PARITY_EN
    sendBit(parityOk ? (^data) : ~(^data));
`else
    if (parityOk === 1'bx) $display("[TB] parity flag undefined");
`endif
    sendBit(stopBit);
    rx = 1'b1;
  endtask

  // Monitor: sample away from the active edge, count pulses, score every handshake beat
  always @(negedge clk) begin
    if (resetn) begin
      if (ferr) ferrCount++;
      if (ovr) ovrCount++;
      if (tvalid && tready) begin
        beatCount++;
        if (expQ.size() == 0) checkOutput("unexpectedBeat", int'(tdata), 999);
        else checkOutput("beatData", int'(tdata), int'(expQ.pop_front()));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int b0;
    int f0;
    int o0;

    vecs.push_back('{"vec00", 8'h00, 1'b1, 1'b1, 1, 0});
    vecs.push_back('{"vecFF", 8'hFF, 1'b1, 1'b1, 1, 0});
    vecs.push_back('{"vecA5", 8'hA5, 1'b1, 1'b1, 1, 0});
    vecs.push_back('{"vecLowStop", 8'h3C, 1'b0, 1'b1, 0, 1});
    vecs.push_back('{"vec81", 8'h81, 1'b1, 1'b1, 1, 0});
`ifdef SVO_UART_RX_PARITY_EN
    vecs.push_back('{"parGood07", 8'h07, 1'b1, 1'b1, 1, 0});
    vecs.push_back('{"parBad07", 8'h07, 1'b1, 1'b0, 0, 1});
`endif

    // Reset state
    resetn = 1'b0;
    rx     = 1'b1;
    tready = 1'b1;
    repeat (3) tick();
    checkOutput("resetTvalid", int'(tvalid), 0);
    checkOutput("resetFrameErr", int'(ferr), 0);
    checkOutput("resetOverrun", int'(ovr), 0);
    resetn = 1'b1;
    repeat (5) tick();

    // Single byte with latency measurement from the start edge
    expQ.push_back(8'h41);
    cyc = 0;
    fork
      applyStimulus(8'h41, 1'b1, 1'b1);
      begin
        while (!tvalid && cyc < 200) begin
          tick();
          cyc++;
        end
      end
    join
    checkCount++;
    if (cyc >= 95 && cyc <= 99) passCount++;
    else $display("[TB] FAIL startLatency: got %0d cycles, expected 95..99", cyc);
    repeat (15) tick();
    checkOutput("singleBeats", beatCount, 1);
    checkOutput("singleFerr", ferrCount, 0);
    checkOutput("singleOvr", ovrCount, 0);

    // Table-driven frames
    foreach (vecs[k]) begin
      b0 = beatCount;
      f0 = ferrCount;
      if (vecs[k].expBeats == 1) expQ.push_back(vecs[k].data);
      applyStimulus(vecs[k].data, vecs[k].stopBit, vecs[k].parityOk);
      repeat (20) tick();
      checkOutput({vecs[k].name, "Beats"}, beatCount - b0, vecs[k].expBeats);
      checkOutput({vecs[k].name, "Ferr"}, ferrCount - f0, vecs[k].expFerr);
    end

    // Glitch: 3 low cycles must not start a frame, and the receiver must still work afterwards
    b0 = beatCount;
    f0 = ferrCount;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (20) tick();
    checkOutput("glitchBeats", beatCount - b0, 0);
    checkOutput("glitchFerr", ferrCount - f0, 0);
    expQ.push_back(8'h5A);
    applyStimulus(8'h5A, 1'b1, 1'b1);
    repeat (20) tick();
    checkOutput("afterGlitchBeats", beatCount - b0, 1);

    // Framing error followed by a held-low break, then a good byte
    b0 = beatCount;
    f0 = ferrCount;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(1'((8'h55 >> i) & 1));
`ifdef SVO_UART_RX_PARITY_EN
    sendBit(1'b0);
`endif
    rx = 1'b0;
    repeat (DIV + 40) tick();
    rx = 1'b1;
    repeat (20) tick();
    checkOutput("breakFerr", ferrCount - f0, 1);
    checkOutput("breakBeats", beatCount - b0, 0);
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1, 1'b1);
    repeat (20) tick();
    checkOutput("afterBreakBeats", beatCount - b0, 1);
    checkOutput("afterBreakFerr", ferrCount - f0, 1);

    // Reset during data bit 4 of 0xFF discards it; 0x3C afterwards is received
    b0 = beatCount;
    f0 = ferrCount;
    fork
      applyStimulus(8'hFF, 1'b1, 1'b1);
      begin
        repeat (DIV * 5 + 3) tick();
        resetn = 1'b0;
        repeat (3) tick();
        checkOutput("midResetTvalid", int'(tvalid), 0);
        resetn = 1'b1;
      end
    join
    repeat (20) tick();
    expQ.push_back(8'h3C);
    applyStimulus(8'h3C, 1'b1, 1'b1);
    repeat (20) tick();
    checkOutput("midResetBeats", beatCount - b0, 1);
    checkOutput("midResetFerr", ferrCount - f0, 0);

    // Back-pressure: 17 bytes into a 16-deep FIFO, then drain
    tready = 1'b0;
    b0 = beatCount;
    o0 = ovrCount;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) expQ.push_back(8'(i));
      applyStimulus(8'(i), 1'b1, 1'b1);
    end
    repeat (20) tick();
    checkOutput("overrunPulses", ovrCount - o0, 1);
    checkOutput("stalledBeats", beatCount - b0, 0);
    checkOutput("stalledTvalid", int'(tvalid), 1);
    checkOutput("stalledHead", int'(tdata), 0);
    tready = 1'b1;
    repeat (30) tick();
    checkOutput("drainBeats", beatCount - b0, DEPTH);
    checkOutput("drainTvalid", int'(tvalid), 0);
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
